instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] are ignored.
REQ-002 The block SHALL have parameter QDEPTH, default 4: instruction queue depth; power of two and at least 2.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port imem_addr, output, 32 bits: byte address driven to the instruction memory, equal to fetch_pc.
REQ-006 Port imem_rd, input, 32 bits: word at imem_addr, returned combinationally in the same cycle.
REQ-007 Port imem_rd2, input, 32 bits: word at imem_addr+4, returned combinationally in the same cycle.
REQ-008 Port redirect, input, 1 bit: branch or jump taken; flush the queue and refetch.
REQ-009 Port redirect_pc, input, 32 bits: new fetch target; sampled only when redirect=1.
REQ-010 Port out_valid, output, 1 bit: the queue head is presented to decode.
REQ-011 Port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 Port out_instr, output, 32 bits: head instruction word.
REQ-013 Port out_pc, output, 32 bits: byte address of the head instruction.

Function
REQ-014 Internal state SHALL be: fetch_pc (32 bits, word-aligned), a circular queue of QDEPTH {instr, pc} entries, read and write pointers, and count (0..QDEPTH).
REQ-015 imem_addr SHALL equal {fetch_pc[31:2], 2'b00} at all times.
REQ-016 push SHALL be true when redirect=0 and count <= QDEPTH-2. The check uses the registered count only and does not credit a same-cycle pop.
REQ-017 On push, the block SHALL write {imem_rd, fetch_pc} then {imem_rd2, fetch_pc+4} into consecutive slots, and advance fetch_pc by 8.
REQ-018 fetch_pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0004 after a push, and the second entry's pc is 32'h0000_0000.
REQ-019 out_valid SHALL equal (count != 0) && !redirect; out_instr and out_pc SHALL show the head entry whenever count != 0.
REQ-020 pop SHALL occur when out_valid && out_ready.
REQ-021 On a simultaneous push and pop, the block SHALL compute count_next = count + 2 - 1.
REQ-022 Queue pointers SHALL wrap modulo QDEPTH.
REQ-023 On redirect=1, in the next state: count=0; rd_ptr=wr_ptr=0; fetch_pc={redirect_pc[31:2],2'b00}; no push and no pop that cycle; any out_ready that cycle is ignored.
REQ-024 A redirect held for several cycles SHALL re-flush every cycle, and the last redirect_pc SHALL win.
REQ-025 Fetch-to-output latency SHALL be 1 cycle: words fetched in cycle N are visible at the head in cycle N+1 if the queue was empty.
REQ-026 Sustained throughput SHALL be 1 instruction per cycle whenever out_ready=1 continuously.
REQ-027 When out_ready=0, the queue SHALL fill to QDEPTH, or QDEPTH-1 if the last pair does not fit. Fetch then halts with fetch_pc held and no entry overwritten.
REQ-028 Queue full/empty SHALL be derived from count only, never from pointer equality.

Reset
REQ-029 While rst_n=0, the block SHALL set: fetch_pc={RESET_PC[31:2],2'b00}, count=0, pointers=0, out_valid=0.
REQ-030 While rst_n=0, out_instr and out_pc SHALL read 32'h0 (queue storage cleared or head output gated).
REQ-031 Assertion of rst_n=0 mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-032 The first push SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the word width (32), RESET_PC default, PC increment constants (4, 8), and the queue entry typedef {instr[31:0], pc[31:0]}.
REQ-034 The queue SHALL be one sub-module, fetch_queue: 2-write/1-read circular buffer with count, parameterised by QDEPTH.
REQ-035 PC and redirect control SHALL stay in instr_fetch_unit.

Verification
REQ-036 Reset release with RESET_PC=0, memory word[i]=32'h1000_0000+i, out_ready=1 -> out_pc sequence 0,4,8,C..., out_instr 32'h1000_0000, 32'h1000_0001...; one instruction per cycle after a 1-cycle start.
REQ-037 out_ready=0 for 10 cycles -> count settles at 4, imem_addr frozen at 32'h10, no lost or duplicate entries after out_ready returns to 1.
REQ-038 redirect=1 with redirect_pc=32'h0000_0103 while count=3 -> next cycle out_valid=0 and imem_addr=32'h100; the cycle after, out_pc=32'h100 with word[64].
REQ-039 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 in order.
REQ-040 rst_n pulsed low between clock edges while count=4 -> out_valid=0 immediately; the restart reproduces the REQ-036 sequence from RESET_PC.
REQ-041 Random out_ready and redirect over 10k cycles against a reference model -> every accepted {out_pc, out_instr} equals the model.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN              : data / address word width
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   PC_INC_4/PC_INC_8 : single-word and fetch-pair address increments
//   PC_ALIGN_MASK     : clears the byte offset of a fetch address
//   fq_entry_t        : one instruction queue slot {instr, pc}
package instr_fetch_unit_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC_4         = 32'd4;
   localparam logic [31:0] PC_INC_8         = 32'd8;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: 2-write / 1-read circular instruction buffer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : drop all entries and zero both pointers
//   push_i       : write wr0_i then wr1_i into two consecutive slots
//   pop_i        : retire the head entry
//   wr0_i, wr1_i : entries written on push
//   head_o       : head entry, zero whenever the queue is empty
//   count_o      : number of valid entries, 0..QDEPTH
// The caller guarantees a push only when two slots are free and a pop
// only when the queue is non-empty; fullness is tracked by count alone.
module fetch_queue
   import instr_fetch_unit_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = $clog2(QDEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  fq_entry_t     wr0_i,
   input  fq_entry_t     wr1_i,
   output fq_entry_t     head_o,
   output logic [CW-1:0] count_o
);

   fq_entry_t     entries_q [QDEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en;

   assign wr_en = push_i && !flush_i;

   // QDEPTH is a power of two, so pointer arithmetic wraps naturally.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(2);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + (push_i ? CW'(2) : CW'(0)) - (pop_i ? CW'(1) : CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head output is gated by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         entries_q[wr_ptr_q]          <= wr0_i;
         entries_q[wr_ptr_q + PW'(1)] <= wr1_i;
      end
   end

   assign head_o  = (count_q != '0) ? entries_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction pairs into a small queue and
// presents them one per cycle to decode.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_addr             : word-aligned fetch address (fetch_pc)
//   imem_rd, imem_rd2     : words at imem_addr and imem_addr+4 (same cycle)
//   redirect, redirect_pc : taken branch/jump; flush and refetch from target
//   out_valid, out_ready  : head handshake towards decode
//   out_instr, out_pc     : head instruction word and its byte address
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rd,
   input  logic [XLEN-1:0] imem_rd2,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int CW = $clog2(QDEPTH + 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   fq_entry_t       wr0, wr1, head;

   // Push needs two free slots in the registered count; a same-cycle pop
   // is deliberately not credited so the check stays off the decode path.
   assign push      = !redirect && (count <= CW'(QDEPTH - 2));
   assign out_valid = (count != '0) && !redirect;
   assign pop       = out_valid && out_ready;

   assign wr0 = '{instr: imem_rd,  pc: fetch_pc_q};
   assign wr1 = '{instr: imem_rd2, pc: fetch_pc_q + PC_INC_4};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc & PC_ALIGN_MASK;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + PC_INC_8;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC & PC_ALIGN_MASK;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_fetch_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect),
      .push_i  (push),
      .pop_i   (pop),
      .wr0_i   (wr0),
      .wr1_i   (wr1),
      .head_o  (head),
      .count_o (count)
   );

   assign imem_addr = fetch_pc_q;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

endmodule
